// File: rtl/dmem_responder_if.sv
// Data-port bus between the SCPU data side and dmem_responder.
// Carries the request (req/we/addr/wdata/be) and the response (rdata/ready/err).
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ready, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ready, err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder for the SCPU data port.
// Word RAM plus an MMIO window at addr[31:28]==4'hF (LED register, cycle counter).
// Each request is answered WAIT_CYCLES+1 cycles after it is accepted.
// Optional feature macro DM_ERR_EN: flags out-of-range RAM and misaligned accesses
// (err with ready, write suppressed, read returns 32'hDEADBEEF). Undefined: err is 0.
//
// state  | meaning
// IDLE   | waiting for req; latches the request when it arrives
// WAIT   | counting down the wait states
// RESP   | performs the access and raises ready for one cycle
module dmem_responder #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 0,
  parameter int LED_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  dmem_responder_if.slave  bus,
  output logic [LED_W-1:0] led
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   cycle_cnt;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH];

  logic          is_mmio;
  logic [1:0]    mmio_off;
  logic [AW-1:0] word_idx;
  logic [31:0]   be_mask;
  logic          acc_err;
  logic          ram_we;
  logic [31:0]   rd_val;
  logic          unused_addr_bits;

  assign is_mmio  = (addr_q[31:28] == 4'hF);
  assign mmio_off = addr_q[3:2];
  assign word_idx = addr_q[AW+1:2];
  assign be_mask  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

`ifdef DM_ERR_EN
  assign acc_err = (!is_mmio && (|addr_q[27:AW+2])) || (|addr_q[1:0]);
`else
  assign acc_err = 1'b0;
`endif
  // Upper RAM address bits alias in the default build; kept only for the error check.
  assign unused_addr_bits = ^{addr_q[27:AW+2], addr_q[1:0]};

  assign ram_we = (state == S_RESP) && we_q && !is_mmio && !acc_err;

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;

  // Read mux: error pattern, MMIO registers, or the addressed RAM word.
  always_comb begin
    rd_val = '0;
    if (acc_err) begin
      rd_val = 32'hDEAD_BEEF;
    end else if (is_mmio) begin
      case (mmio_off)
        2'd0:    rd_val[LED_W-1:0] = led;
        2'd1:    rd_val = cycle_cnt;
        default: rd_val = '0;
      endcase
    end else begin
      rd_val = mem[word_idx];
    end
  end

  // RAM write port; contents are deliberately not reset. An async reset forces
  // IDLE, so an access aborted by reset never reaches this write.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[word_idx] <= (mem[word_idx] & ~be_mask) | (wdata_q & be_mask);
    end
  end

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Request FSM with registered response outputs and the LED register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      led      <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            be_q    <= bus.be;
            if (WAIT_CYCLES > 0) begin
              wait_cnt <= 4'(WAIT_CYCLES - 1);
              state    <= S_WAIT;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          ready_q <= 1'b1;
          err_q   <= acc_err;
          if (!we_q) begin
            rdata_q <= rd_val;
          end else if (is_mmio && (mmio_off == 2'd0) && !acc_err) begin
            led <= (led & ~be_mask[LED_W-1:0]) | (wdata_q[LED_W-1:0] & be_mask[LED_W-1:0]);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
